// File: rtl/sopc_pio_ext.sv
// Avalon-MM PIO slave: output register with set/clear/toggle aliases, synchronised inputs
// with edge capture, maskable level IRQ. Zero-wait-state; readdata is combinational.
module sopc_pio_ext #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               EDGE_TYPE   = 0,
   parameter int               SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [WIDTH-1:0] in_prev_q, in_prev_d;
   logic [WIDTH-1:0] out_reg_q, out_reg_d;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
   logic [2:0]       prime_cnt_q, prime_cnt_d;

   logic             wr;
   logic             primed;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] in_sync;
   logic [WIDTH-1:0] edge_v;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] rd_w;

   assign wr      = chipselect & ~write_n;
   assign wd      = writedata[WIDTH-1:0];
   assign in_sync = sync_q[SYNC_STAGES-1];
   assign primed  = (prime_cnt_q == PRIME_MAX);

   always_comb begin
      sync_d[0] = in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      in_prev_d   = in_sync;
      prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + 3'd1;
   end

   always_comb begin
      if (EDGE_TYPE == 0) begin
         edge_v = in_sync & ~in_prev_q;
      end else if (EDGE_TYPE == 1) begin
         edge_v = ~in_sync & in_prev_q;
      end else begin
         edge_v = in_sync ^ in_prev_q;
      end
   end

   always_comb begin
      out_reg_d  = out_reg_q;
      irq_mask_d = irq_mask_q;
      w1c        = '0;
      if (wr) begin
         case (address)
            3'd0, 3'd1: out_reg_d  = wd;
            3'd2:       irq_mask_d = wd;
            3'd3:       w1c        = wd;
            3'd4:       out_reg_d  = out_reg_q | wd;
            3'd5:       out_reg_d  = out_reg_q & ~wd;
            3'd6:       out_reg_d  = out_reg_q ^ wd;
            default:    ;
         endcase
      end
      // New edges are OR'd in after the clear so a coincident W1C never loses an edge.
      edge_cap_d = (edge_cap_q & ~w1c) | (primed ? edge_v : '0);
   end

   always_comb begin
      rd_w = '0;
      case (address)
         3'd0:    rd_w = in_sync;
         3'd1:    rd_w = out_reg_q;
         3'd2:    rd_w = irq_mask_q;
         3'd3:    rd_w = edge_cap_q;
         default: rd_w = '0;
      endcase
      readdata = 32'(rd_w);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         in_prev_q   <= '0;
         out_reg_q   <= RESET_VALUE;
         irq_mask_q  <= '0;
         edge_cap_q  <= '0;
         prime_cnt_q <= '0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         in_prev_q   <= in_prev_d;
         out_reg_q   <= out_reg_d;
         irq_mask_q  <= irq_mask_d;
         edge_cap_q  <= edge_cap_d;
         prime_cnt_q <= prime_cnt_d;
      end
   end

   assign out_port = out_reg_q;
   assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_sopc_pio_ext.sv
// Directed bench for sopc_pio_ext: a 32-bit and an 8-bit instance sharing the bus lines.
module tb_sopc_pio_ext;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        cs32 = 1'b0;
   logic        cs8 = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] rd32, rd8;
   logic [31:0] in32 = '0;
   logic [7:0]  in8 = '0;
   logic [31:0] out32;
   logic [7:0]  out8;
   logic        irq32, irq8;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   sopc_pio_ext #(.WIDTH(32), .RESET_VALUE(32'h0000_00A5), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs32), .write_n(write_n),
      .writedata(writedata), .readdata(rd32), .in_port(in32), .out_port(out32), .irq(irq32));

   sopc_pio_ext #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut8 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs8), .write_n(write_n),
      .writedata(writedata), .readdata(rd8), .in_port(in8), .out_port(out8), .irq(irq8));

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic use8);
      @(negedge clk);
      address = a; writedata = d; write_n = 1'b0;
      if (use8) cs8 = 1'b1; else cs32 = 1'b1;
      @(negedge clk);
      write_n = 1'b1; cs32 = 1'b0; cs8 = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; in32 = '0; in8 = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      #1;
      tests_run++; if (out32 !== 32'hA5) begin tests_failed++; $display("FAIL reset_out got %h want %h", out32, 32'hA5); end
      tests_run++; if (irq32 !== 1'b0) begin tests_failed++; $display("FAIL reset_irq got %b want 0", irq32); end
      address = 3'd1; #1;
      tests_run++; if (rd32 !== 32'hA5) begin tests_failed++; $display("FAIL reset_rd1 got %h want %h", rd32, 32'hA5); end
      address = 3'd3; #1;
      tests_run++; if (rd32 !== 32'h0) begin tests_failed++; $display("FAIL reset_rd3 got %h want 0", rd32); end
      address = 3'd0; #1;
      tests_run++; if (rd32 !== 32'h0) begin tests_failed++; $display("FAIL reset_rd0 got %h want 0", rd32); end
   endtask

   task automatic test_out_aliases;
      logic [31:0] exp [4];
      logic [2:0]  adr [4];
      logic [31:0] dat [4];
      exp = '{32'h0F, 32'hFF, 32'hF3, 32'h1F2};
      adr = '{3'd0, 3'd4, 3'd5, 3'd6};
      dat = '{32'h0F, 32'hF0, 32'h0C, 32'h101};
      for (int i = 0; i < 4; i++) begin
         bus_write(adr[i], dat[i], 1'b0);
         tests_run++;
         if (out32 !== exp[i]) begin
            tests_failed++; $display("FAIL alias_%0d got %h want %h", i, out32, exp[i]);
         end
      end
   endtask

   task automatic test_edge_capture;
      bus_write(3'd2, 32'h1, 1'b0);
      address = 3'd3; #1;
      tests_run++; if (rd32 !== 32'h0) begin tests_failed++; $display("FAIL edge_pre got %h want 0", rd32); end
      @(negedge clk); in32[0] = 1'b1;
      @(negedge clk); #1;
      tests_run++; if (irq32 !== 1'b0) begin tests_failed++; $display("FAIL edge_clk1 irq got %b want 0", irq32); end
      @(negedge clk); #1;
      tests_run++; if (irq32 !== 1'b0) begin tests_failed++; $display("FAIL edge_clk2 irq got %b want 0", irq32); end
      @(negedge clk); #1;
      tests_run++; if (irq32 !== 1'b1) begin tests_failed++; $display("FAIL edge_clk3 irq got %b want 1", irq32); end
      tests_run++; if (rd32 !== 32'h1) begin tests_failed++; $display("FAIL edge_clk3 cap got %h want 1", rd32); end
      in32[0] = 1'b0;
      bus_write(3'd3, 32'h1, 1'b0);
      repeat (6) @(negedge clk);
      address = 3'd3; #1;
      tests_run++; if (rd32 !== 32'h0) begin tests_failed++; $display("FAIL edge_fall cap got %h want 0", rd32); end
      tests_run++; if (irq32 !== 1'b0) begin tests_failed++; $display("FAIL edge_fall irq got %b want 0", irq32); end
   endtask

   task automatic test_w1c_collision;
      @(negedge clk); in32[0] = 1'b1;
      repeat (3) @(negedge clk);
      address = 3'd3; #1;
      tests_run++; if (rd32 !== 32'h1) begin tests_failed++; $display("FAIL coll_setup got %h want 1", rd32); end
      in32[0] = 1'b0;
      repeat (6) @(negedge clk);
      @(negedge clk); in32[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      address = 3'd3; writedata = 32'h1; write_n = 1'b0; cs32 = 1'b1;
      #1;
      tests_run++; if (irq32 !== 1'b1) begin tests_failed++; $display("FAIL coll_pre irq got %b want 1", irq32); end
      @(negedge clk);
      write_n = 1'b1; cs32 = 1'b0;
      #1;
      tests_run++; if (rd32 !== 32'h1) begin tests_failed++; $display("FAIL coll_cap got %h want 1", rd32); end
      tests_run++; if (irq32 !== 1'b1) begin tests_failed++; $display("FAIL coll_irq got %b want 1", irq32); end
      bus_write(3'd3, 32'h1, 1'b0);
      tests_run++; if (rd32 !== 32'h0) begin tests_failed++; $display("FAIL coll_clr cap got %h want 0", rd32); end
      tests_run++; if (irq32 !== 1'b0) begin tests_failed++; $display("FAIL coll_clr irq got %b want 0", irq32); end
   endtask

   task automatic test_prime;
      @(negedge clk);
      in32 = 32'hFFFF_FFFF;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      address = 3'd3;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         tests_run++;
         if (rd32 !== 32'h0 || irq32 !== 1'b0) begin
            tests_failed++; $display("FAIL prime_clk%0d cap %h irq %b want 0/0", i, rd32, irq32);
         end
      end
      bus_write(3'd2, 32'hFFFF_FFFF, 1'b0);
      tests_run++; if (irq32 !== 1'b0) begin tests_failed++; $display("FAIL prime_masked irq got %b want 0", irq32); end
      address = 3'd0; #1;
      tests_run++; if (rd32 !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL prime_rd0 got %h want ffffffff", rd32); end
   endtask

   task automatic test_width8;
      bus_write(3'd1, 32'hFFFF_FFFF, 1'b1);
      address = 3'd1; #1;
      tests_run++; if (rd8 !== 32'h0000_00FF) begin tests_failed++; $display("FAIL w8_rd1 got %h want 000000ff", rd8); end
      tests_run++; if (out8 !== 8'hFF) begin tests_failed++; $display("FAIL w8_out got %h want ff", out8); end
      for (int a = 4; a < 8; a++) begin
         address = 3'(a); #1;
         tests_run++;
         if (rd8 !== 32'h0) begin tests_failed++; $display("FAIL w8_rd%0d got %h want 0", a, rd8); end
      end
      bus_write(3'd1, 32'h0000_1234, 1'b0);
      @(negedge clk); #2;
      reset_n = 1'b0;
      #1;
      tests_run++; if (out8 !== 8'hA5) begin tests_failed++; $display("FAIL w8_arst out8 got %h want a5", out8); end
      tests_run++; if (out32 !== 32'hA5) begin tests_failed++; $display("FAIL w8_arst out32 got %h want a5", out32); end
      address = 3'd2; #1;
      tests_run++; if (rd32 !== 32'h0) begin tests_failed++; $display("FAIL w8_arst mask got %h want 0", rd32); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_out_aliases();
      test_edge_capture();
      test_w1c_collision();
      test_prime();
      test_width8();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
